sample_buffer_writer: RTL
=========================

// Module: sample_buffer_writer
// PURPOSE
//  Producer side of the FFT input sample buffer. Captures a stream of ADC/audio samples and writes one
//  frame of 2**ADDR_W samples, in natural order, into the dual-port input buffer. Then requests a
//  transform on the address generator's start input. It holds the buffer untouched until the
//  generator's LOAD pass has finished reading it, and then starts the next frame.
// PARAMETERS
//  ADDR_W  10  buffer address width; frame length N = 2**ADDR_W (1024)
//  DATA_W  16  sample width (two's complement, passed through unchanged)
//  DECIM   1   keep one of every DECIM valid samples (1..256); 1 = no decimation
// PORTS
//  clk             in   1       system clock
//  rst_n           in   1       reset; asynchronous, active-low
//  enable_i        in   1       continuous-capture enable
//  sample_i        in   DATA_W  incoming sample
//  sample_valid_i  in   1       sample_i qualifier, single-cycle strobes
//  loading_i       in   1       address generator loading_o (high while it reads the buffer)
//  wr_en_o         out  1       buffer write enable
//  wr_addr_o       out  ADDR_W  buffer write address
//  wr_data_o       out  DATA_W  buffer write data
//  start_o         out  1       transform request, drives address generator start_i
//  busy_o          out  1       high in every state except IDLE
//  overrun_o       out  1       sticky: a kept sample arrived while the buffer was not accepting
//  frames_o        out  8       count of completed hand-offs, wraps 255->0
// BEHAVIOUR
//  - Reset (async): state=IDLE and every output is 0. The address and decimation counters are cleared.
//  - All outputs are registered. The write for an accepted sample appears on the edge after its strobe
//    (1-cycle latency), with wr_en_o high for exactly 1 cycle.
//  - Decimation: a modulo-DECIM counter advances on each sample_valid_i that arrives in FILL. A sample is
//    kept only when the count is 0. The counter clears on entry to FILL.
//  - States:
//    IDLE: enable_i=1 -> FILL. On this entry, addr=0 and overrun_o is cleared.
//    FILL: each kept sample is written at addr, then addr increments.
//      The kept sample written at addr=N-1 -> HANDOFF, and addr wraps to 0.
//      enable_i=0 -> IDLE. The partial frame is discarded, start_o is never raised, and a write
//      already in its latency cycle still completes.
//    HANDOFF: start_o=1 from the cycle after the last wr_en_o, held as a level until loading_i=1
//      is seen -> HOLD, with start_o=0 on the next edge.
//      The level hold is required because the generator ignores start while a transform is running.
//    HOLD: no writes. loading_i 1->0 -> frames_o+1, then FILL if enable_i=1, else IDLE.
//  - In HANDOFF/HOLD, kept samples are dropped and overrun_o is set. A sample is kept when it would
//    pass the decimation test, and the counter keeps running in these states.
//    overrun_o clears only on reset or on IDLE->FILL.
//  - Simultaneous events:
//    sample_valid_i in the same cycle as the FILL->HANDOFF transition: the sample is dropped
//    (overrun_o set).
//    loading_i already 1 on HANDOFF entry: HOLD is entered next cycle, and start_o still pulses
//    for at least 1 cycle.
//  - enable_i is ignored in HANDOFF/HOLD, so a requested transform always completes its hand-off.
//  - wr_data_o holds its last value when wr_en_o=0. wr_addr_o and wr_data_o are don't-care unless
//    wr_en_o=1.
// STRUCTURE
//  - Shared package (fft_pkg): state encoding (IDLE/FILL/HANDOFF/HOLD), FFT_ADDR_W=10, SAMPLE_W=16.
//    The address generator's addressing uses the same constants.
//  - One sub-module, sample_decimator: DECIM counter that outputs a keep strobe for each kept sample.
//  - The FSM, address counter, frame counter and overrun flag live in the top module.
// TESTING
//  1. Reset mid-FILL (rst_n low at addr=37) -> all outputs 0 immediately; after release, state is IDLE
//     and addr restarts at 0.
//  2. enable_i=1, 1024 back-to-back valid samples 0..1023 -> writes at addr 0..1023 with data=addr;
//     start_o rises 1 cycle after the addr 1023 write.
//  3. loading_i low for 20 cycles after start_o -> start_o held 20 cycles, then HOLD. loading_i high
//     1024 cycles then low -> frames_o=1 and FILL resumes at addr 0.
//  4. Samples continue during HANDOFF/HOLD -> no wr_en_o, overrun_o=1. The next IDLE->FILL entry
//     clears overrun_o.
//  5. DECIM=4, 4096 valid samples -> 1024 writes, of samples 0,4,8,...; wr_data_o[N-1]=4092.
//  6. enable_i dropped at addr=500 -> IDLE, no start_o. Re-enabling refills from addr 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Constants and state encoding shared by the FFT input-buffer writer and the address generator.
package fft_pkg;

    localparam int FFT_ADDR_W = 10;
    localparam int SAMPLE_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL    = 2'd1,
        ST_HANDOFF = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

endpackage

// File: rtl/sample_decimator.sv
// Modulo-DECIM sample counter: flags the valid strobes that survive decimation.
module sample_decimator #(
    parameter int DECIM = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic advance_i,
    output logic keep_o
);

    localparam logic [7:0] LAST_COUNT = 8'(DECIM - 1);

    logic [7:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 8'd0;
        end else if (clear_i) begin
            r_count <= 8'd0;
        end else if (advance_i) begin
            r_count <= (r_count == LAST_COUNT) ? 8'd0 : r_count + 8'd1;
        end
    end

    assign keep_o = advance_i && (r_count == 8'd0);

endmodule

// File: rtl/sample_buffer_writer.sv
// Fills one natural-order frame of the FFT input buffer, then hands it to the
// address generator and waits for its LOAD pass to finish before refilling.
module sample_buffer_writer
    import fft_pkg::*;
#(
    parameter int ADDR_W = FFT_ADDR_W,
    parameter int DATA_W = SAMPLE_W,
    parameter int DECIM  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_i,
    input  logic [DATA_W-1:0] sample_i,
    input  logic              sample_valid_i,
    input  logic              loading_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic              start_o,
    output logic              busy_o,
    output logic              overrun_o,
    output logic [7:0]        frames_o
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_start;
    logic              r_busy;
    logic              r_overrun;
    logic [7:0]        r_frames;

    logic w_keep;
    logic w_advance;
    logic w_fill_entry;
    logic w_write;
    logic w_drop;
    logic w_start_next;
    logic w_frame_done;

    // The decimation count runs in every non-IDLE state so drops are judged on the same grid.
    assign w_advance    = sample_valid_i && (r_state != ST_IDLE);
    assign w_fill_entry = (w_state_next == ST_FILL) && (r_state != ST_FILL);

    sample_decimator #(
        .DECIM(DECIM)
    ) u_decimator (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (w_fill_entry),
        .advance_i(w_advance),
        .keep_o   (w_keep)
    );

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (enable_i) begin
                    w_state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                if (!enable_i) begin
                    w_state_next = ST_IDLE;
                end else if (w_keep && (r_addr == ADDR_LAST)) begin
                    w_state_next = ST_HANDOFF;
                end
            end
            ST_HANDOFF: begin
                if (loading_i) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!loading_i) begin
                    w_state_next = enable_i ? ST_FILL : ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_write      = (r_state == ST_FILL) && enable_i && w_keep;
    assign w_drop       = w_keep && ((r_state == ST_HANDOFF) || (r_state == ST_HOLD));
    // HOLD is only entered on loading_i=1, so a low loading_i in HOLD is the end of the LOAD pass.
    assign w_frame_done = (r_state == ST_HOLD) && !loading_i;
    // Start is always raised for at least one cycle, even if loading_i is already high on entry.
    assign w_start_next = (r_state == ST_HANDOFF) && !(loading_i && r_start);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_start   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
            r_frames  <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != ST_IDLE);
            r_start <= w_start_next;
            r_wr_en <= w_write;

            if (w_write) begin
                r_wr_addr <= r_addr;
                r_wr_data <= sample_i;
                r_addr    <= r_addr + ADDR_W'(1);
            end else if ((r_state == ST_IDLE) && enable_i) begin
                r_addr <= '0;
            end

            if ((r_state == ST_IDLE) && enable_i) begin
                r_overrun <= 1'b0;
            end else if (w_drop) begin
                r_overrun <= 1'b1;
            end

            if (w_frame_done) begin
                r_frames <= r_frames + 8'd1;
            end
        end
    end

    assign wr_en_o   = r_wr_en;
    assign wr_addr_o = r_wr_addr;
    assign wr_data_o = r_wr_data;
    assign start_o   = r_start;
    assign busy_o    = r_busy;
    assign overrun_o = r_overrun;
    assign frames_o  = r_frames;

endmodule
